// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port synchronous VRAM between the video fetcher and a
// buffered CPU request port. Video owns even clock slots and the CPU owns odd
// slots, so video fetches are never stalled. CPU requests go through a small
// in-order FIFO and one entry is retired per CPU slot.
//
// Ports:
//   I_clock, I_reset            system clock, asynchronous active-low reset
//   I_vid_addr / O_vid_data     video fetch address and returned data
//   I_cpu_valid / O_cpu_ready   CPU request handshake (FIFO push)
//   I_cpu_we, I_cpu_addr,
//   I_cpu_wdata                 CPU request contents
//   O_cpu_rvalid / O_cpu_rdata  one-cycle CPU read-return pulse and data
//   O_ram_addr, O_ram_we,
//   O_ram_wdata, I_ram_rdata    RAM side (outputs registered)
//
// Build option: define VRAM_CPU_READ_EN to build the CPU read-return path.
// Without it, CPU reads are accepted and dropped on pop, and the read-return
// outputs are tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SLOT_VID | video slot: register fetch address, tag window hit
// SLOT_CPU | CPU slot: pop one FIFO entry (write, read, or drop)

module vram_arbiter #(
    parameter logic [15:0] P_addr_base  = 16'h4000,
    parameter int unsigned P_addr_bits  = 12,
    parameter int unsigned P_fifo_depth = 4
) (
    input  logic                   I_clock,
    input  logic                   I_reset,
    input  logic [15:0]            I_vid_addr,
    output logic [7:0]             O_vid_data,
    input  logic                   I_cpu_valid,
    output logic                   O_cpu_ready,
    input  logic                   I_cpu_we,
    input  logic [15:0]            I_cpu_addr,
    input  logic [7:0]             I_cpu_wdata,
    output logic                   O_cpu_rvalid,
    output logic [7:0]             O_cpu_rdata,
    output logic [P_addr_bits-1:0] O_ram_addr,
    output logic                   O_ram_we,
    output logic [7:0]             O_ram_wdata,
    input  logic [7:0]             I_ram_rdata
);

    localparam int unsigned        L_ptr_w = (P_fifo_depth > 1) ? $clog2(P_fifo_depth) : 1;
    localparam logic [L_ptr_w:0]   L_full  = (L_ptr_w + 1)'(P_fifo_depth);

    typedef enum logic {
        SLOT_VID = 1'b0,
        SLOT_CPU = 1'b1
    } slot_e;

    slot_e                  slot_q;
    logic [L_ptr_w-1:0]     wr_ptr_q;
    logic [L_ptr_w-1:0]     rd_ptr_q;
    logic [L_ptr_w:0]       count_q;
    logic [L_ptr_w:0]       count_d;
    logic                   ready_q;

    logic                   fifo_we_q    [P_fifo_depth];
    logic [15:0]            fifo_addr_q  [P_fifo_depth];
    logic [7:0]             fifo_wdata_q [P_fifo_depth];

    logic [P_addr_bits-1:0] ram_addr_q;
    logic                   ram_we_q;
    logic [7:0]             ram_wdata_q;

    // Two-stage tag pipeline following the RAM access: stage 1 aligns with
    // the registered address, stage 2 with the cycle I_ram_rdata is valid.
    logic                   s1_vid_q;
    logic                   s1_inwin_q;
    logic                   s2_vid_q;
    logic                   s2_inwin_q;
    logic [7:0]             vid_data_q;

    logic                   push;
    logic                   pop;
    logic                   head_we;
    logic [15:0]            head_addr;
    logic [7:0]             head_wdata;
    logic [15:0]            vid_off;
    logic [15:0]            cpu_off;
    logic                   vid_inwin;
    logic                   cpu_inwin;

`ifdef VRAM_CPU_READ_EN
    logic                   s1_rd_q;
    logic                   s2_rd_q;
    logic                   rvalid_q;
    logic [7:0]             rdata_q;
`endif

    assign push       = I_cpu_valid && ready_q;
    // Pop uses the count registered before this edge, so an entry pushed in
    // a CPU slot is never bypassed into that same slot.
    assign pop        = (slot_q == SLOT_CPU) && (count_q != '0);

    assign head_we    = fifo_we_q[rd_ptr_q];
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_wdata = fifo_wdata_q[rd_ptr_q];

    // 16-bit wrap-around offset; the window hit is offset < 2^P_addr_bits.
    assign vid_off    = I_vid_addr - P_addr_base;
    assign cpu_off    = head_addr - P_addr_base;
    assign vid_inwin  = (vid_off >> P_addr_bits) == 16'd0;
    assign cpu_inwin  = (cpu_off >> P_addr_bits) == 16'd0;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge I_clock) begin
        if (push) begin
            fifo_we_q[wr_ptr_q]    <= I_cpu_we;
            fifo_addr_q[wr_ptr_q]  <= I_cpu_addr;
            fifo_wdata_q[wr_ptr_q] <= I_cpu_wdata;
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            slot_q      <= SLOT_VID;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            s1_vid_q    <= 1'b0;
            s1_inwin_q  <= 1'b0;
            s2_vid_q    <= 1'b0;
            s2_inwin_q  <= 1'b0;
            vid_data_q  <= '0;
`ifdef VRAM_CPU_READ_EN
            s1_rd_q     <= 1'b0;
            s2_rd_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
`endif
        end else begin
            slot_q  <= (slot_q == SLOT_VID) ? SLOT_CPU : SLOT_VID;
            count_q <= count_d;
            ready_q <= (count_d != L_full);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            s2_vid_q   <= s1_vid_q;
            s2_inwin_q <= s1_inwin_q;
            if (s2_vid_q) begin
                vid_data_q <= s2_inwin_q ? I_ram_rdata : 8'h00;
            end
`ifdef VRAM_CPU_READ_EN
            s2_rd_q  <= s1_rd_q;
            rvalid_q <= s2_rd_q;
            if (s2_rd_q) begin
                rdata_q <= s2_inwin_q ? I_ram_rdata : 8'h00;
            end
            s1_rd_q  <= 1'b0;
`endif

            ram_we_q   <= 1'b0;
            s1_vid_q   <= 1'b0;
            s1_inwin_q <= 1'b0;

            if (slot_q == SLOT_VID) begin
                ram_addr_q <= vid_off[P_addr_bits-1:0];
                s1_vid_q   <= 1'b1;
                s1_inwin_q <= vid_inwin;
            end else if (pop) begin
                if (head_we) begin
                    // Out-of-window writes are consumed without touching RAM.
                    if (cpu_inwin) begin
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= cpu_off[P_addr_bits-1:0];
                        ram_wdata_q <= head_wdata;
                    end
                end else begin
`ifdef VRAM_CPU_READ_EN
                    ram_addr_q <= cpu_off[P_addr_bits-1:0];
                    s1_rd_q    <= 1'b1;
                    s1_inwin_q <= cpu_inwin;
`endif
                end
            end
        end
    end

    assign O_cpu_ready  = ready_q;
    assign O_vid_data   = vid_data_q;
    assign O_ram_addr   = ram_addr_q;
    assign O_ram_we     = ram_we_q;
    assign O_ram_wdata  = ram_wdata_q;
`ifdef VRAM_CPU_READ_EN
    assign O_cpu_rvalid = rvalid_q;
    assign O_cpu_rdata  = rdata_q;
`else
    assign O_cpu_rvalid = 1'b0;
    assign O_cpu_rdata  = 8'h00;
`endif

endmodule
